// File: rtl/nco_config_sequencer.sv
// NCO configuration sequencer: latches UI selections at state commits and glides
// the phase increment toward the committed frequency target.
module nco_config_sequencer #(
  parameter int PHASE_W   = 24,
  parameter int BASE_INC  = 1678,
  parameter int STEP      = 64,
  parameter int GLIDE_DIV = 10
) (
  input  logic               clk_1MHz,
  input  logic               rst,
  input  logic [2:0]         state_in,
  input  logic [1:0]         sw_wave,
  input  logic [3:0]         sw_freq,
  output logic [1:0]         wave_sel,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               cfg_valid,
  output logic               cfg_strobe,
  output logic               out_en,
  output logic [1:0]         disp_mode,
  output logic               state_err
);

  localparam int                 DIV_W    = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(GLIDE_DIV - 1);
  localparam logic [PHASE_W-1:0] STEP_V   = PHASE_W'(STEP);
  localparam logic [PHASE_W+4:0] BASE_V   = (PHASE_W+5)'(BASE_INC);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_RAMP = 2'd1,
    G_DONE = 2'd2
  } glide_t;

  logic [2:0]         state_r;
  logic [2:0]         state_d_r;
  logic [1:0]         wave_r;
  logic [3:0]         freq_r;
  logic               wave_commit_r;
  logic               freq_commit_r;
  logic               zero_entry_r;
  logic [PHASE_W-1:0] target_r;
  logic [DIV_W-1:0]   div_r;
  glide_t             glide_r;
  logic [PHASE_W-1:0] next_inc_s;

  // Product is formed 5 bits wider so an oversized BASE_INC saturates instead of wrapping.
  function automatic logic [PHASE_W-1:0] sat_target(input logic [3:0] idx);
    logic [PHASE_W+4:0] prod;
    logic [PHASE_W-1:0] res;
    prod = BASE_V * {{PHASE_W{1'b0}}, ({1'b0, idx} + 5'd1)};
    if (|prod[PHASE_W+4:PHASE_W]) res = {PHASE_W{1'b1}};
    else                          res = prod[PHASE_W-1:0];
    return res;
  endfunction

  function automatic logic [PHASE_W-1:0] step_toward(input logic [PHASE_W-1:0] cur,
                                                     input logic [PHASE_W-1:0] tgt);
    logic [PHASE_W-1:0] res;
    if (cur < tgt)      res = ((tgt - cur) <= STEP_V) ? tgt : cur + STEP_V;
    else if (cur > tgt) res = ((cur - tgt) <= STEP_V) ? tgt : cur - STEP_V;
    else                res = tgt;
    return res;
  endfunction

  // Next glide value, clamped so a step never overshoots the target.
  always_comb begin
    next_inc_s = step_toward(phase_inc, target_r);
  end

  // Input registration and commit/clear edge detection (detections are registered).
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state_r       <= 3'd0;
      state_d_r     <= 3'd0;
      wave_r        <= 2'd0;
      freq_r        <= 4'd0;
      wave_commit_r <= 1'b0;
      freq_commit_r <= 1'b0;
      zero_entry_r  <= 1'b0;
    end else begin
      state_r       <= state_in;
      state_d_r     <= state_r;
      wave_r        <= sw_wave;
      freq_r        <= sw_freq;
      wave_commit_r <= (state_d_r == 3'd1) && (state_r == 3'd2);
      freq_commit_r <= (state_d_r == 3'd3) && (state_r == 3'd4);
      zero_entry_r  <= (state_d_r != 3'd0) && (state_r == 3'd0);
    end
  end

  // Committed configuration and glide FSM; returning to state 0 wins over any commit.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      wave_sel   <= 2'd0;
      target_r   <= {PHASE_W{1'b0}};
      phase_inc  <= {PHASE_W{1'b0}};
      cfg_strobe <= 1'b0;
      div_r      <= {DIV_W{1'b0}};
      glide_r    <= G_IDLE;
    end else if (zero_entry_r) begin
      wave_sel   <= 2'd0;
      target_r   <= {PHASE_W{1'b0}};
      phase_inc  <= {PHASE_W{1'b0}};
      cfg_strobe <= 1'b0;
      div_r      <= {DIV_W{1'b0}};
      glide_r    <= G_IDLE;
    end else begin
      if (wave_commit_r) wave_sel <= wave_r;
      if (freq_commit_r) target_r <= sat_target(freq_r);
      cfg_strobe <= 1'b0;
      case (glide_r)
        G_IDLE: begin
          if (phase_inc != target_r) begin
            glide_r <= G_RAMP;
            div_r   <= {DIV_W{1'b0}};
          end
        end
        G_RAMP: begin
          if (div_r == DIV_LAST) begin
            div_r     <= {DIV_W{1'b0}};
            phase_inc <= next_inc_s;
            if (next_inc_s == target_r) begin
              glide_r    <= G_DONE;
              cfg_strobe <= 1'b1;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        G_DONE:  glide_r <= G_IDLE;
        default: glide_r <= G_IDLE;
      endcase
    end
  end

  // Display mode, output enable and sticky illegal-code flag; codes 6/7 hold outputs.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      out_en    <= 1'b0;
      disp_mode <= 2'd0;
      state_err <= 1'b0;
    end else begin
      state_err <= state_err | (state_r[2:1] == 2'b11);
      case (state_r)
        3'd0: begin disp_mode <= 2'd0; out_en <= 1'b0; end
        3'd1: begin disp_mode <= 2'd1; out_en <= 1'b0; end
        3'd2, 3'd3: begin disp_mode <= 2'd2; out_en <= 1'b0; end
        3'd4, 3'd5: begin disp_mode <= 2'd3; out_en <= (phase_inc != {PHASE_W{1'b0}}); end
        default: begin disp_mode <= disp_mode; out_en <= out_en; end
      endcase
    end
  end

  assign cfg_valid = (glide_r != G_RAMP) && (phase_inc == target_r) &&
                     (target_r != {PHASE_W{1'b0}});

endmodule

// File: tb/tb_nco_config_sequencer.sv
// Self-checking bench for nco_config_sequencer: randomized commits checked against
// an arithmetic model of targets, glide step counts and commit latency.
`timescale 1ns/1ps
module tb_nco_config_sequencer;

  localparam int PHASE_W   = 24;
  localparam int BASE_INC  = 1678;
  localparam int STEP      = 64;
  localparam int GLIDE_DIV = 10;

  logic               clk_1MHz = 1'b0;
  logic               rst;
  logic [2:0]         state_in;
  logic [1:0]         sw_wave;
  logic [3:0]         sw_freq;
  logic [1:0]         wave_sel;
  logic [PHASE_W-1:0] phase_inc;
  logic               cfg_valid;
  logic               cfg_strobe;
  logic               out_en;
  logic [1:0]         disp_mode;
  logic               state_err;

  int checks = 0;
  int errors = 0;
  int cur_inc = 0;
  int cur_wave = 0;

  nco_config_sequencer #(
    .PHASE_W(PHASE_W), .BASE_INC(BASE_INC), .STEP(STEP), .GLIDE_DIV(GLIDE_DIV)
  ) dut (
    .clk_1MHz(clk_1MHz), .rst(rst), .state_in(state_in), .sw_wave(sw_wave),
    .sw_freq(sw_freq), .wave_sel(wave_sel), .phase_inc(phase_inc),
    .cfg_valid(cfg_valid), .cfg_strobe(cfg_strobe), .out_en(out_en),
    .disp_mode(disp_mode), .state_err(state_err)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  function automatic int model_target(input int idx);
    longint p;
    longint mx;
    p  = longint'(BASE_INC) * longint'(idx + 1);
    mx = (longint'(1) << PHASE_W) - 1;
    return (p > mx) ? int'(mx) : int'(p);
  endfunction

  function automatic int model_steps(input int from, input int to);
    int d;
    d = (to > from) ? (to - from) : (from - to);
    return (d + STEP - 1) / STEP;
  endfunction

  task automatic tick();
    @(posedge clk_1MHz);
    #1;
  endtask

  task automatic hold_state(input logic [2:0] s, input int n);
    state_in = s;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; state_in = 3'd0; sw_wave = 2'd0; sw_freq = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    cur_inc = 0; cur_wave = 0;
  endtask

  task automatic start_commit(input int idx);
    sw_freq = 4'(idx);
    hold_state(3'd3, 3);
    state_in = 3'd4;
  endtask

  task automatic wait_inc(input int value);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      tick();
      if (int'(phase_inc) == value) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_inc: phase_inc=%0d never reached required %0d", phase_inc, value);
    end
  endtask

  task automatic run_commit(input int idx);
    int tgt, n, first_k, strobes, prev, delta, budget;
    bit step_ok;
    start_commit(idx);
    tgt = model_target(idx);
    n = model_steps(cur_inc, tgt);
    first_k = -1; strobes = 0; prev = cur_inc; step_ok = 1'b1;
    budget = (n == 0) ? 60 : 4 + n * GLIDE_DIV + 20;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (cfg_strobe) begin
        strobes++;
        if (first_k < 0) first_k = k;
      end
      if (int'(phase_inc) != prev) begin
        delta = int'(phase_inc) - prev;
        if (!(delta == STEP || delta == -STEP ||
              (int'(phase_inc) == tgt && delta <= STEP && delta >= -STEP))) step_ok = 1'b0;
        prev = int'(phase_inc);
      end
    end
    checks++;
    if (int'(phase_inc) !== tgt) begin
      errors++;
      $display("FAIL glide_final idx=%0d: phase_inc=%0d required %0d", idx, phase_inc, tgt);
    end
    checks++;
    if (strobes !== ((n == 0) ? 0 : 1)) begin
      errors++;
      $display("FAIL strobe_count idx=%0d: got %0d required %0d", idx, strobes, (n == 0) ? 0 : 1);
    end
    checks++;
    if (cfg_valid !== 1'b1 || out_en !== 1'b1) begin
      errors++;
      $display("FAIL valid_en idx=%0d: cfg_valid=%b out_en=%b required 1 1", idx, cfg_valid, out_en);
    end
    if (n > 0) begin
      checks++;
      if (first_k !== 4 + n * GLIDE_DIV) begin
        errors++;
        $display("FAIL glide_latency idx=%0d: strobe at clk %0d required %0d", idx, first_k, 4 + n * GLIDE_DIV);
      end
      checks++;
      if (!step_ok) begin
        errors++;
        $display("FAIL glide_steps idx=%0d: step size not %0d (or clamp) got 0 required 1", idx, STEP);
      end
    end
    cur_inc = tgt;
  endtask

  task automatic test_reset();
    checks++;
    if ({wave_sel, phase_inc, cfg_valid, cfg_strobe, out_en, disp_mode, state_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: wave=%0d inc=%0d valid=%b strobe=%b en=%b disp=%0d err=%b required all 0",
               wave_sel, phase_inc, cfg_valid, cfg_strobe, out_en, disp_mode, state_err);
    end
  endtask

  task automatic test_wave_commit();
    int w;
    w = $urandom_range(3, 1);
    sw_wave = 2'(w);
    hold_state(3'd0, 3);
    hold_state(3'd1, 3);
    checks++;
    if (disp_mode !== 2'd1) begin
      errors++;
      $display("FAIL disp_s1: disp_mode=%0d required 1", disp_mode);
    end
    hold_state(3'd2, 2);
    checks++;
    if (disp_mode !== 2'd2 || wave_sel !== 2'd0) begin
      errors++;
      $display("FAIL wave_early: disp=%0d wave_sel=%0d required 2 0", disp_mode, wave_sel);
    end
    tick();
    checks++;
    if (wave_sel !== 2'(w)) begin
      errors++;
      $display("FAIL wave_commit: wave_sel=%0d required %0d", wave_sel, w);
    end
    cur_wave = w;
  endtask

  task automatic test_ramp_up();
    run_commit(3);
  endtask

  task automatic test_same_target();
    run_commit(3);
  endtask

  task automatic test_illegal();
    int strobes;
    bit held;
    strobes = 0; held = 1'b1;
    sw_freq = 4'd9;
    hold_state(3'd7, 1);
    state_in = 3'd4;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (cfg_strobe) strobes++;
      if (wave_sel !== 2'(cur_wave) || int'(phase_inc) !== cur_inc || disp_mode !== 2'd3) held = 1'b0;
    end
    checks++;
    if (state_err !== 1'b1) begin
      errors++;
      $display("FAIL state_err_set: state_err=%b required 1", state_err);
    end
    checks++;
    if (!held || strobes !== 0) begin
      errors++;
      $display("FAIL illegal_hold: held=%b strobes=%0d required 1 0", held, strobes);
    end
  endtask

  task automatic test_mid_ramp_clear();
    int strobes;
    strobes = 0;
    hold_state(3'd0, 4);
    cur_inc = 0; cur_wave = 0;
    start_commit(3);
    wait_inc(3200);
    hold_state(3'd0, 4);
    checks++;
    if (phase_inc !== '0 || wave_sel !== 2'd0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_ramp_clear: inc=%0d wave=%0d valid=%b required 0 0 0", phase_inc, wave_sel, cfg_valid);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (cfg_strobe) strobes++;
    end
    checks++;
    if (strobes !== 0 || phase_inc !== '0) begin
      errors++;
      $display("FAIL clear_quiet: strobes=%0d inc=%0d required 0 0", strobes, phase_inc);
    end
    checks++;
    if (state_err !== 1'b1) begin
      errors++;
      $display("FAIL state_err_sticky: state_err=%b required 1", state_err);
    end
  endtask

  task automatic test_ramp_down();
    run_commit(15);
    run_commit(0);
  endtask

  task automatic test_random_glides();
    for (int i = 0; i < 3; i++) run_commit(int'($urandom_range(15, 0)));
  endtask

  task automatic test_reset_mid_ramp();
    int strobes;
    strobes = 0;
    hold_state(3'd0, 4);
    cur_inc = 0;
    start_commit(3);
    wait_inc(3200);
    #100 rst = 1'b1;
    #1;
    checks++;
    if ({wave_sel, phase_inc, cfg_valid, cfg_strobe, out_en, disp_mode, state_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: inc=%0d wave=%0d valid=%b strobe=%b en=%b disp=%0d err=%b required all 0",
               phase_inc, wave_sel, cfg_valid, cfg_strobe, out_en, disp_mode, state_err);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (cfg_strobe) strobes++;
    end
    checks++;
    if (strobes !== 0 || phase_inc !== '0) begin
      errors++;
      $display("FAIL post_reset_quiet: strobes=%0d inc=%0d required 0 0", strobes, phase_inc);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_wave_commit();
    test_ramp_up();
    test_same_target();
    test_illegal();
    test_mid_ramp_clear();
    test_ramp_down();
    test_random_glides();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
